// File: rtl/sdcmd_tx_if.sv
// sdcmd_tx_if: command handshake and CMD-line driver signals for the SD command transmitter
interface sdcmd_tx_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [5:0]  i_cmd_index;
    logic [31:0] i_cmd_arg;
    logic        i_cmd_abort;
    logic        o_cmd_en;
    logic        o_cmd_data;
    logic        o_busy;
    logic        o_done;
    modport slave (
        input  i_cmd_valid, i_cmd_index, i_cmd_arg, i_cmd_abort,
        output o_cmd_ready, o_cmd_en, o_cmd_data, o_busy, o_done
    );
    modport master (
        output i_cmd_valid, i_cmd_index, i_cmd_arg, i_cmd_abort,
        input  o_cmd_ready, o_cmd_en, o_cmd_data, o_busy, o_done
    );
endinterface

// File: rtl/sdcmd_tx.sv
// sdcmd_tx: frames an SD command with CRC7 and serialises it on the CMD pin at SD clock falling edges
module sdcmd_tx #(
    parameter int NTRAIL = 2
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_hlfck,
    sdcmd_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, TRAIL} state_t;
    localparam logic [3:0] LP_NTRAIL = 4'(NTRAIL);
    state_t      r_state;
    logic [39:0] r_sr;
    logic [6:0]  r_crc;
    logic [5:0]  r_cnt;
    logic [3:0]  r_tcnt;
    logic        r_cmd_en;
    logic        r_cmd_data;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_done;
    logic        w_accept;
    logic        w_abort;
    logic        w_release;
    logic        w_fb;
    logic [6:0]  w_crc_nxt;
    assign bus.o_cmd_en    = r_cmd_en;
    assign bus.o_cmd_data  = r_cmd_data;
    assign bus.o_cmd_ready = r_cmd_ready;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    // accept/abort/release decisions and the next CRC7 value for the bit leaving the shift register
    always_comb begin
        w_accept  = bus.i_cmd_valid && r_cmd_ready && !bus.i_cmd_abort;
        w_abort   = r_state != IDLE && bus.i_cmd_abort;
        w_release = i_hlfck && ((r_state == SHIFT && r_cnt == 6'd0 && NTRAIL == 0) ||
                                (r_state == TRAIL && r_tcnt == LP_NTRAIL));
        w_fb      = r_sr[39] ^ r_crc[6];
        w_crc_nxt = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
    end
    // frame FSM: r_cnt holds the index of the bit currently on the line
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cmd_en    <= 1'b0;
            r_cmd_data  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_abort || w_release) begin
            r_state     <= IDLE;
            r_cmd_en    <= 1'b0;
            r_cmd_data  <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= !w_abort;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= !w_accept;
                    if (w_accept) begin
                        r_sr    <= {2'b01, bus.i_cmd_index, bus.i_cmd_arg};
                        r_crc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: if (i_hlfck) begin
                    r_cmd_en   <= 1'b1;
                    r_cmd_data <= r_sr[39];
                    r_sr       <= {r_sr[38:0], 1'b0};
                    r_crc      <= w_crc_nxt;
                    r_cnt      <= 6'd47;
                    r_state    <= SHIFT;
                end
                SHIFT: if (i_hlfck) begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd0) begin
                        r_cmd_data <= 1'b1;
                        r_tcnt     <= 4'd1;
                        r_state    <= TRAIL;
                    end else if (r_cnt > 6'd8) begin
                        r_cmd_data <= r_sr[39];
                        r_sr       <= {r_sr[38:0], 1'b0};
                        r_crc      <= w_crc_nxt;
                    end else if (r_cnt > 6'd1) begin
                        r_cmd_data <= r_crc[6];
                        r_crc      <= {r_crc[5:0], 1'b0};
                    end else begin
                        r_cmd_data <= 1'b1;
                    end
                end
                TRAIL: if (i_hlfck) r_tcnt <= r_tcnt + 4'd1;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
